column_access_seq: RTL and testbench
====================================

Name: column_access_seq

Overview:
- Sequenced, parametrised column decoder for the SRAM array datapath.
- Accepts one column access per request and drives precharge for a fixed number of cycles. It then drives the enable lines of one column group, steered from the bit-line pattern BL, for a fixed number of cycles.
- Signals completion with a one-cycle pulse.
- Generalises the static 16-bit, 2-group decode to BL_W bits, COLS groups (non-power-of-two allowed) and programmable phase timing, with out-of-range detection.

Parameters:
- BL_W, 16, bit lines per column group
- COLS, 2, number of column groups; ADR_W = max(1, $clog2(COLS))
- PRE_CYC, 1, precharge phase length in cycles (>=1)
- EN_CYC, 2, enable phase length in cycles (>=1)

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  reset, asynchronous assert, active-low
- REQ  in  1  access request, level; held by requester until READY=1
- ADR  in  ADR_W  column group select; sampled on accept
- BL  in  BL_W  bit-line pattern; sampled on accept
- READY  out  1  block idle, REQ accepted this cycle if high
- PRE  out  1  precharge enable
- BLE  out  BL_W*COLS  bit-line enables; group g occupies bits [g*BL_W +: BL_W]
- DONE  out  1  one-cycle completion pulse
- ERR  out  1  valid with DONE; 1 = ADR was >= COLS

Behaviour:
- One clock domain (CLK); reset is asynchronous and active-low (RST_N).
- Reset: state=IDLE, READY=1, PRE=0, BLE=0, DONE=0, ERR=0, latched ADR/BL=0. Assertion mid-operation aborts immediately, with all outputs at reset values asynchronously. The first accept is possible on the first edge after deassertion.
- All outputs are registered or decoded from state flops only. There is no combinational path from inputs to outputs.
- Accept happens on an edge where state=IDLE and REQ=1. On accept, ADR and BL are latched into ADR_q and BL_q; later changes on ADR/BL are ignored.
- States:
  - IDLE: READY=1, all else 0. On accept -> PRE if ADR < COLS, else DONE with an error flag.
  - PRE: PRE=1, BLE=0 for exactly PRE_CYC cycles (phase counter) -> EN.
  - EN: BLE[ADR_q*BL_W +: BL_W] = BL_q and all other bits 0, for exactly EN_CYC cycles -> DONE.
  - DONE: DONE=1 for one cycle, ERR = error flag -> IDLE.
- Latency, measured from the accept edge:
  - PRE is high on cycles 1..PRE_CYC.
  - BLE is active on cycles PRE_CYC+1..PRE_CYC+EN_CYC.
  - DONE is on cycle PRE_CYC+EN_CYC+1.
  - READY returns the cycle after DONE.
  - Minimum request period is PRE_CYC+EN_CYC+2. The error path takes 2 cycles (DONE, then IDLE).
- Break-before-make: PRE and any BLE bit are never high in the same cycle. Only one group is ever non-zero.
- REQ while READY=0 is ignored, with no queueing. REQ held high through DONE is accepted in the following IDLE cycle (back-to-back).
- BL_q=0 with a valid ADR runs the full sequence with BLE all zero. DONE=1, ERR=0.
- Phase counter width is $clog2(max(PRE_CYC,EN_CYC)+1). It reloads on every phase entry and never wraps past its terminal count.
- Elaboration check: fatal if PRE_CYC<1, EN_CYC<1, COLS<1 or BL_W<1.

Decomposition:
- Package column_pkg:
  - state enum col_state_t {IDLE, PRE, EN, DONE}
  - phase-length helper function
  - shared ADR_W derivation function
- Sub-module column_group_decoder: combinational ADR_q + BL_q -> BL_W*COLS enable vector, plus an in_range flag. Reused by the future write-driver block.
- The top level holds the FSM, phase counter, input latches and output registers.

Test Plan:
- Defaults; REQ=1, ADR=1, BL=16'hA5A5 -> READY low from cycle 1; PRE=1 on cycle 1; BLE=32'hA5A5_0000 on cycles 2-3; DONE=1, ERR=0 on cycle 4; READY=1 on cycle 5.
- COLS=3, BL_W=8; ADR=2'd3 -> PRE and BLE never assert; DONE=1, ERR=1 on cycle 1; READY on cycle 2.
- PRE_CYC=3, EN_CYC=1, ADR=0, BL=16'hFFFF; BL changed to 0 on cycle 1 -> PRE on cycles 1-3; BLE=32'h0000_FFFF on cycle 4 only; DONE on cycle 5.
- REQ held high continuously with ADR alternating 0/1 -> accepts every 5 cycles with defaults; second REQ pulse during EN is ignored; assertion checks PRE&|BLE==0 throughout.
- RST_N low during EN (defaults) -> BLE=0, PRE=0, DONE=0, READY=1 immediately without a clock edge; after release, a new request completes normally.
- BL=0, ADR=0 -> full timing with BLE=0; DONE=1, ERR=0 on cycle 4.

Source files
------------

// File: rtl/column_pkg.sv
// Shared types and elaboration helpers for the column access sequencer
// and the column group decoder.
package column_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PRE  = 2'd1;
  localparam logic [1:0] ST_EN   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    PRE  = ST_PRE,
    EN   = ST_EN,
    DONE = ST_DONE
  } col_state_t;

  // A single-group array still carries a one-bit select so out-of-range can be flagged.
  function automatic int adr_width(input int cols);
    return (cols <= 2) ? 1 : $clog2(cols);
  endfunction

  function automatic int max_phase(input int pre_cyc, input int en_cyc);
    return (pre_cyc > en_cyc) ? pre_cyc : en_cyc;
  endfunction

  function automatic int phase_cnt_width(input int pre_cyc, input int en_cyc);
    return $clog2(max_phase(pre_cyc, en_cyc) + 1);
  endfunction

endpackage

// File: rtl/column_group_decoder.sv
// Steers a bit-line pattern onto one column group of the enable vector and
// reports whether the group select addresses an existing group.
module column_group_decoder
  import column_pkg::*;
#(
  parameter int BL_W = 16,
  parameter int COLS = 2,
  localparam int ADR_W = adr_width(COLS)
) (
  input  logic [ADR_W-1:0]     adr,
  input  logic [BL_W-1:0]      bl,
  output logic [BL_W*COLS-1:0] ble,
  output logic                 in_range
);

  always_comb begin
    ble = '0;
    for (int g = 0; g < COLS; g++) begin
      if (adr == ADR_W'(g)) begin
        ble[g*BL_W +: BL_W] = bl;
      end
    end
  end

  assign in_range = 32'(adr) < 32'(COLS);

endmodule

// File: rtl/column_access_seq.sv
// Sequenced column access: precharge phase, then one column group enabled
// from the latched bit-line pattern, then a one-cycle completion pulse.
module column_access_seq
  import column_pkg::*;
#(
  parameter int BL_W    = 16,
  parameter int COLS    = 2,
  parameter int PRE_CYC = 1,
  parameter int EN_CYC  = 2,
  localparam int ADR_W  = adr_width(COLS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req,
  input  logic [ADR_W-1:0]     adr,
  input  logic [BL_W-1:0]      bl,
  output logic                 ready,
  output logic                 pre,
  output logic [BL_W*COLS-1:0] ble,
  output logic                 done,
  output logic                 err,
  output col_state_t           dbg_state
);

  localparam int CW = phase_cnt_width(PRE_CYC, EN_CYC);

  if (PRE_CYC < 1 || EN_CYC < 1 || COLS < 1 || BL_W < 1) begin : g_param_check
    $fatal(1, "column_access_seq: PRE_CYC, EN_CYC, COLS and BL_W must all be >= 1");
  end

  // Handshake: req is a level held by the requester; it is taken on the edge
  // where ready=1 and req=1, and ignored (not queued) while ready=0.
  col_state_t          state_q;
  logic [CW-1:0]       cnt_q;
  logic [ADR_W-1:0]    adr_q;
  logic [BL_W-1:0]     bl_q;
  logic [BL_W*COLS-1:0] dec_ble;
  logic                dec_in_range;
  logic                adr_ok;

  assign adr_ok = 32'(adr) < 32'(COLS);

  column_group_decoder #(
    .BL_W (BL_W),
    .COLS (COLS)
  ) u_dec (
    .adr      (adr_q),
    .bl       (bl_q),
    .ble      (dec_ble),
    .in_range (dec_in_range)
  );

  // The counter is reloaded on each phase entry and stops at zero, which is
  // the exit condition, so it can never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      bl_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            adr_q <= adr;
            bl_q  <= bl;
            if (adr_ok) begin
              state_q <= PRE;
              cnt_q   <= CW'(PRE_CYC - 1);
            end else begin
              state_q <= DONE;
            end
          end
        end
        PRE: begin
          if (cnt_q == '0) begin
            state_q <= EN;
            cnt_q   <= CW'(EN_CYC - 1);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        EN: begin
          if (cnt_q == '0) begin
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Outputs decode only state and latched flops, so reset clears them at once.
  assign ready     = (state_q == IDLE);
  assign pre       = (state_q == PRE);
  assign ble       = (state_q == EN) ? dec_ble : '0;
  assign done      = (state_q == DONE);
  assign err       = (state_q == DONE) && !dec_in_range;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_column_access_seq.sv
// Bench for column_access_seq: default build, a 3-group 8-bit build and a
// long-precharge build, checked cycle by cycle against an expected-frame queue.
module tb_column_access_seq;
  import column_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  // Frame layout: {ready, pre, done, err, ble[31:0]}
  logic [35:0] exp_q[$];

  // Default build: BL_W=16, COLS=2, PRE_CYC=1, EN_CYC=2
  logic        d0_req, d0_ready, d0_pre, d0_done, d0_err;
  logic [0:0]  d0_adr;
  logic [15:0] d0_bl;
  logic [31:0] d0_ble;
  col_state_t  d0_state;

  // COLS=3, BL_W=8
  logic        d1_req, d1_ready, d1_pre, d1_done, d1_err;
  logic [1:0]  d1_adr;
  logic [7:0]  d1_bl;
  logic [23:0] d1_ble;
  col_state_t  d1_state;

  // PRE_CYC=3, EN_CYC=1
  logic        d2_req, d2_ready, d2_pre, d2_done, d2_err;
  logic [0:0]  d2_adr;
  logic [15:0] d2_bl;
  logic [31:0] d2_ble;
  col_state_t  d2_state;

  column_access_seq dut0 (
    .clk(clk), .rst_n(rst_n), .req(d0_req), .adr(d0_adr), .bl(d0_bl),
    .ready(d0_ready), .pre(d0_pre), .ble(d0_ble), .done(d0_done), .err(d0_err),
    .dbg_state(d0_state)
  );

  column_access_seq #(.BL_W(8), .COLS(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(d1_req), .adr(d1_adr), .bl(d1_bl),
    .ready(d1_ready), .pre(d1_pre), .ble(d1_ble), .done(d1_done), .err(d1_err),
    .dbg_state(d1_state)
  );

  column_access_seq #(.PRE_CYC(3), .EN_CYC(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(d2_req), .adr(d2_adr), .bl(d2_bl),
    .ready(d2_ready), .pre(d2_pre), .ble(d2_ble), .done(d2_done), .err(d2_err),
    .dbg_state(d2_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [35:0] obs0();
    return {d0_ready, d0_pre, d0_done, d0_err, d0_ble};
  endfunction

  function automatic logic [35:0] obs1();
    return {d1_ready, d1_pre, d1_done, d1_err, 8'h00, d1_ble};
  endfunction

  function automatic logic [35:0] obs2();
    return {d2_ready, d2_pre, d2_done, d2_err, d2_ble};
  endfunction

  // Expected frames for one access, cycles 1.. after the accept edge, ending
  // with the idle cycle that follows DONE.
  task automatic push_access(input int pc, input int ec, input int a,
                             input logic [31:0] b, input int cols, input int blw);
    logic [31:0] v;
    v = '0;
    if (a >= cols) begin
      exp_q.push_back({4'b0011, 32'h0});
    end else begin
      for (int i = 0; i < blw; i++) v[a*blw + i] = b[i];
      repeat (pc) exp_q.push_back({4'b0100, 32'h0});
      repeat (ec) exp_q.push_back({4'b0000, v});
      exp_q.push_back({4'b0010, 32'h0});
    end
    exp_q.push_back({4'b1000, 32'h0});
  endtask

  // Break-before-make and single-group checks on the default build.
  always @(negedge clk) begin
    checks++;
    if ((d0_pre && (|d0_ble)) || ((|d0_ble[31:16]) && (|d0_ble[15:0]))) begin
      failures++;
      $display("FAIL bbm_onegroup t=%0t pre=%b ble=%h required pre&ble=0 and one group", $time, d0_pre, d0_ble);
    end
  end

  task automatic test_reset();
    logic [35:0] idle_f;
    idle_f = {4'b1000, 32'h0};
    #12;
    checks++;
    if (obs0() !== idle_f) begin
      failures++; $display("FAIL reset_d0 got=%h exp=%h", obs0(), idle_f);
    end
    checks++;
    if (obs1() !== idle_f) begin
      failures++; $display("FAIL reset_d1 got=%h exp=%h", obs1(), idle_f);
    end
    checks++;
    if (obs2() !== idle_f) begin
      failures++; $display("FAIL reset_d2 got=%h exp=%h", obs2(), idle_f);
    end
    checks++;
    if (d0_state !== IDLE) begin
      failures++; $display("FAIL reset_state got=%0d exp=%0d", d0_state, IDLE);
    end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [35:0] e;
    push_access(1, 2, 1, 32'hA5A5, 2, 16);
    d0_adr = 1'b1; d0_bl = 16'hA5A5; d0_req = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      if (k == 1) d0_req = 1'b0;
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL basic_empty cycle=%0d", k);
      end else begin
        e = exp_q.pop_front();
        if (obs0() !== e) begin
          failures++; $display("FAIL basic cycle=%0d got=%h exp=%h", k, obs0(), e);
        end
      end
    end
  endtask

  task automatic test_err();
    logic [35:0] e;
    push_access(1, 2, 3, 32'h5A, 3, 8);
    d1_adr = 2'd3; d1_bl = 8'h5A; d1_req = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk); #1;
      if (k == 1) d1_req = 1'b0;
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL err_empty cycle=%0d", k);
      end else begin
        e = exp_q.pop_front();
        if (obs1() !== e) begin
          failures++; $display("FAIL err_path cycle=%0d got=%h exp=%h", k, obs1(), e);
        end
      end
    end
  endtask

  task automatic test_latch();
    logic [35:0] e;
    push_access(3, 1, 0, 32'hFFFF, 2, 16);
    d2_adr = 1'b0; d2_bl = 16'hFFFF; d2_req = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        d2_req = 1'b0; d2_bl = 16'h0000; d2_adr = 1'b1;
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL latch_empty cycle=%0d", k);
      end else begin
        e = exp_q.pop_front();
        if (obs2() !== e) begin
          failures++; $display("FAIL latch cycle=%0d got=%h exp=%h", k, obs2(), e);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [35:0] e;
    logic [15:0] pat[3];
    for (int i = 0; i < 3; i++) pat[i] = 16'($urandom_range(1, 16'hFFFF));
    push_access(1, 2, 0, {16'h0, pat[0]}, 2, 16);
    push_access(1, 2, 1, {16'h0, pat[1]}, 2, 16);
    push_access(1, 2, 0, {16'h0, pat[2]}, 2, 16);
    d0_adr = 1'b0; d0_bl = pat[0]; d0_req = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      if (k == 1)  begin d0_adr = 1'b1; d0_bl = pat[1]; end
      if (k == 6)  begin d0_adr = 1'b0; d0_bl = pat[2]; end
      if (k == 11) d0_req = 1'b0;
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL b2b_empty cycle=%0d", k);
      end else begin
        e = exp_q.pop_front();
        if (obs0() !== e) begin
          failures++; $display("FAIL b2b cycle=%0d got=%h exp=%h", k, obs0(), e);
        end
      end
    end
  endtask

  task automatic test_ignore_req();
    logic [35:0] e;
    push_access(1, 2, 1, 32'h1234, 2, 16);
    d0_adr = 1'b1; d0_bl = 16'h1234; d0_req = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      if (k == 1) d0_req = 1'b0;
      if (k == 2) begin d0_req = 1'b1; d0_adr = 1'b0; d0_bl = 16'hFFFF; end
      if (k == 3) d0_req = 1'b0;
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL ignore_empty cycle=%0d", k);
      end else begin
        e = exp_q.pop_front();
        if (obs0() !== e) begin
          failures++; $display("FAIL ignore_req cycle=%0d got=%h exp=%h", k, obs0(), e);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [35:0] e;
    push_access(1, 2, 1, 32'hBEEF, 2, 16);
    d0_adr = 1'b1; d0_bl = 16'hBEEF; d0_req = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk); #1;
      if (k == 1) d0_req = 1'b0;
      checks++;
      e = exp_q.pop_front();
      if (obs0() !== e) begin
        failures++; $display("FAIL rstmid_pre cycle=%0d got=%h exp=%h", k, obs0(), e);
      end
    end
    exp_q.delete();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs0() !== {4'b1000, 32'h0}) begin
      failures++; $display("FAIL rstmid_async got=%h exp=%h", obs0(), {4'b1000, 32'h0});
    end
    checks++;
    if (d0_state !== IDLE) begin
      failures++; $display("FAIL rstmid_state got=%0d exp=%0d", d0_state, IDLE);
    end
    #3 rst_n = 1'b1;
    push_access(1, 2, 0, 32'h5A5A, 2, 16);
    d0_adr = 1'b0; d0_bl = 16'h5A5A; d0_req = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      if (k == 1) d0_req = 1'b0;
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL rstmid_empty cycle=%0d", k);
      end else begin
        e = exp_q.pop_front();
        if (obs0() !== e) begin
          failures++; $display("FAIL rstmid_after cycle=%0d got=%h exp=%h", k, obs0(), e);
        end
      end
    end
  endtask

  task automatic test_zero_bl();
    logic [35:0] e;
    push_access(1, 2, 0, 32'h0, 2, 16);
    d0_adr = 1'b0; d0_bl = 16'h0000; d0_req = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      if (k == 1) d0_req = 1'b0;
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL zero_bl_empty cycle=%0d", k);
      end else begin
        e = exp_q.pop_front();
        if (obs0() !== e) begin
          failures++; $display("FAIL zero_bl cycle=%0d got=%h exp=%h", k, obs0(), e);
        end
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0;
    d0_req = 1'b0; d0_adr = '0; d0_bl = '0;
    d1_req = 1'b0; d1_adr = '0; d1_bl = '0;
    d2_req = 1'b0; d2_adr = '0; d2_bl = '0;
    test_reset();
    test_basic();
    test_err();
    test_latch();
    test_back_to_back();
    test_ignore_req();
    test_reset_mid();
    test_zero_bl();
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL leftover_frames got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
